// File: rtl/fsm_w_pkg.sv
// Shared definitions for the washing-machine controller: state encodings,
// program codes, default phase durations and small decode helpers.
package fsm_w_pkg;

    localparam int TIMER_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_SOAP_WAIT   = 4'd1,
        ST_FILL        = 4'd2,
        ST_WASH        = 4'd3,
        ST_DRAIN       = 4'd4,
        ST_RINSE_FILL  = 4'd5,
        ST_RINSE       = 4'd6,
        ST_RINSE_DRAIN = 4'd7,
        ST_SPIN        = 4'd8,
        ST_DONE        = 4'd9
    } state_t;

    localparam logic [2:0] PROG_COLD_WASH   = 3'b000;
    localparam logic [2:0] PROG_HOT_WASH    = 3'b001;
    localparam logic [2:0] PROG_RINSING_DRY = 3'b010;
    localparam logic [2:0] PROG_ONLY_DRY    = 3'b011;

    localparam logic [TIMER_W-1:0] T_FILL_DEF   = 8'd10;
    localparam logic [TIMER_W-1:0] T_WASH_DEF   = 8'd30;
    localparam logic [TIMER_W-1:0] T_DRAIN_DEF  = 8'd10;
    localparam logic [TIMER_W-1:0] T_RFILL_DEF  = 8'd10;
    localparam logic [TIMER_W-1:0] T_RINSE_DEF  = 8'd20;
    localparam logic [TIMER_W-1:0] T_RDRAIN_DEF = 8'd10;
    localparam logic [TIMER_W-1:0] T_SPIN_DEF   = 8'd20;

    typedef struct packed {
        logic valve_in_cold;
        logic valve_in_hot;
        logic valve_out;
        logic motor;
        logic program_done;
        logic soap_warning;
    } outs_t;

    // Timed phases are the contiguous block FILL..SPIN.
    function automatic logic is_timed(input state_t s);
        return (s == ST_FILL) || (s == ST_WASH) || (s == ST_DRAIN) ||
               (s == ST_RINSE_FILL) || (s == ST_RINSE) ||
               (s == ST_RINSE_DRAIN) || (s == ST_SPIN);
    endfunction

endpackage

// File: rtl/fsm_w_timer.sv
// Loadable phase down-counter; load wins over hold, and the count stops at zero.
module fsm_w_timer
    import fsm_w_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             at_one
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (!hold && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_one = (count_q == WIDTH'(1));

endmodule

// File: rtl/fsm_w.sv
// Washing-machine program sequencer: selects a program on start, steps through
// timed phases, pauses while the door is open and drives registered actuators.
module fsm_w
    import fsm_w_pkg::*;
#(
    parameter logic [TIMER_W-1:0] T_FILL   = T_FILL_DEF,
    parameter logic [TIMER_W-1:0] T_WASH   = T_WASH_DEF,
    parameter logic [TIMER_W-1:0] T_DRAIN  = T_DRAIN_DEF,
    parameter logic [TIMER_W-1:0] T_RFILL  = T_RFILL_DEF,
    parameter logic [TIMER_W-1:0] T_RINSE  = T_RINSE_DEF,
    parameter logic [TIMER_W-1:0] T_RDRAIN = T_RDRAIN_DEF,
    parameter logic [TIMER_W-1:0] T_SPIN   = T_SPIN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power,
    input  logic [2:0] program_selection,
    input  logic       start,
    input  logic       doorclosed,
    input  logic       soap,
    output logic       valve_in_cold,
    output logic       valve_in_hot,
    output logic       valve_out,
    output logic       motor,
    output logic [7:0] timer_display,
    output logic       program_done,
    output logic       soap_warning
);

    state_t               current_state;
    state_t               next_state;
    logic [2:0]           prog_q;
    logic [2:0]           prog_d;
    outs_t                outs_q;
    outs_t                outs_d;
    logic                 timer_load;
    logic                 timer_hold;
    logic                 timer_at_one;
    logic [TIMER_W-1:0]   timer_value;
    logic [TIMER_W-1:0]   timer_count;

    function automatic logic [TIMER_W-1:0] phase_duration(input state_t s);
        case (s)
            ST_FILL:        phase_duration = T_FILL;
            ST_WASH:        phase_duration = T_WASH;
            ST_DRAIN:       phase_duration = T_DRAIN;
            ST_RINSE_FILL:  phase_duration = T_RFILL;
            ST_RINSE:       phase_duration = T_RINSE;
            ST_RINSE_DRAIN: phase_duration = T_RDRAIN;
            ST_SPIN:        phase_duration = T_SPIN;
            default:        phase_duration = '0;
        endcase
    endfunction

    function automatic state_t phase_successor(input state_t s);
        case (s)
            ST_FILL:        phase_successor = ST_WASH;
            ST_WASH:        phase_successor = ST_DRAIN;
            ST_DRAIN:       phase_successor = ST_RINSE_FILL;
            ST_RINSE_FILL:  phase_successor = ST_RINSE;
            ST_RINSE:       phase_successor = ST_RINSE_DRAIN;
            ST_RINSE_DRAIN: phase_successor = ST_SPIN;
            ST_SPIN:        phase_successor = ST_DONE;
            default:        phase_successor = ST_IDLE;
        endcase
    endfunction

    // Power-off dominates; start is only honoured from IDLE/DONE with the door shut.
    always_comb begin
        next_state = current_state;
        prog_d     = prog_q;
        timer_hold = 1'b1;
        if (!power) begin
            next_state = ST_IDLE;
        end else begin
            case (current_state)
                ST_IDLE, ST_DONE: begin
                    if (start && doorclosed) begin
                        case (program_selection)
                            PROG_COLD_WASH, PROG_HOT_WASH: begin
                                prog_d     = program_selection;
                                next_state = soap ? ST_FILL : ST_SOAP_WAIT;
                            end
                            PROG_RINSING_DRY: begin
                                prog_d     = program_selection;
                                next_state = ST_RINSE_FILL;
                            end
                            PROG_ONLY_DRY: begin
                                prog_d     = program_selection;
                                next_state = ST_SPIN;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SOAP_WAIT: begin
                    if (soap) begin
                        next_state = ST_FILL;
                    end
                end
                default: begin
                    if (is_timed(current_state)) begin
                        if (doorclosed) begin
                            timer_hold = 1'b0;
                            if (timer_at_one) begin
                                next_state = phase_successor(current_state);
                            end
                        end
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Every state change reloads the timer; untimed states load zero.
    assign timer_load  = (next_state != current_state);
    assign timer_value = phase_duration(next_state);

    // Outputs are decoded from the upcoming state so they register alongside it.
    always_comb begin
        outs_d = '0;
        case (next_state)
            ST_SOAP_WAIT: outs_d.soap_warning = 1'b1;
            ST_FILL: begin
                outs_d.valve_in_hot  = doorclosed && (prog_d == PROG_HOT_WASH);
                outs_d.valve_in_cold = doorclosed && (prog_d != PROG_HOT_WASH);
            end
            ST_RINSE_FILL:            outs_d.valve_in_cold = doorclosed;
            ST_WASH, ST_RINSE:        outs_d.motor         = doorclosed;
            ST_DRAIN, ST_RINSE_DRAIN: outs_d.valve_out     = doorclosed;
            ST_SPIN: begin
                outs_d.motor     = doorclosed;
                outs_d.valve_out = doorclosed;
            end
            ST_DONE: outs_d.program_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_state <= ST_IDLE;
            prog_q        <= PROG_COLD_WASH;
            outs_q        <= '0;
        end else begin
            current_state <= next_state;
            prog_q        <= prog_d;
            outs_q        <= outs_d;
        end
    end

    fsm_w_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(timer_value),
        .hold      (timer_hold),
        .count     (timer_count),
        .at_one    (timer_at_one)
    );

    assign valve_in_cold = outs_q.valve_in_cold;
    assign valve_in_hot  = outs_q.valve_in_hot;
    assign valve_out     = outs_q.valve_out;
    assign motor         = outs_q.motor;
    assign program_done  = outs_q.program_done;
    assign soap_warning  = outs_q.soap_warning;
    assign timer_display = timer_count;

endmodule

// File: tb/tb_fsm_w.sv
// Bench for fsm_w: a phase-list reference model feeds a per-cycle scoreboard,
// plus directed scenarios and a randomized soak.
module tb_fsm_w;

    logic       clk;
    logic       rst;
    logic       power;
    logic [2:0] sel;
    logic       start;
    logic       door;
    logic       soap;
    logic       valve_in_cold;
    logic       valve_in_hot;
    logic       valve_out;
    logic       motor;
    logic [7:0] timer_display;
    logic       program_done;
    logic       soap_warning;
    logic [3:0] dut_state;

    int checks   = 0;
    int failures = 0;

    logic [17:0] exp_q[$];

    int         m_mode;
    int         m_rem;
    int         m_plan[$];
    logic [2:0] m_prog;

    fsm_w dut (
        .clk              (clk),
        .rst              (rst),
        .power            (power),
        .program_selection(sel),
        .start            (start),
        .doorclosed       (door),
        .soap             (soap),
        .valve_in_cold    (valve_in_cold),
        .valve_in_hot     (valve_in_hot),
        .valve_out        (valve_out),
        .motor            (motor),
        .timer_display    (timer_display),
        .program_done     (program_done),
        .soap_warning     (soap_warning)
    );

    assign dut_state = dut.current_state;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int phaseLen(input int phase);
        case (phase)
            2: return 10;
            3: return 30;
            4: return 10;
            5: return 10;
            6: return 20;
            7: return 10;
            8: return 20;
            default: return 0;
        endcase
    endfunction

    task automatic enterHeadPhase();
        if (m_plan.size() == 0) begin
            m_mode = 9;
            m_rem  = 0;
        end else begin
            m_mode = m_plan[0];
            m_rem  = phaseLen(m_mode);
        end
    endtask

    // Reference model: a program is a list of remaining phases with a cycle budget.
    task automatic modelStep();
        if (rst || !power) begin
            m_mode = 0;
            m_rem  = 0;
            m_plan.delete();
            if (rst) m_prog = 3'b000;
        end else if (m_mode == 0 || m_mode == 9) begin
            if (start && door && sel < 3'd4) begin
                m_prog = sel;
                if (sel <= 3'd1) m_plan = {2, 3, 4, 5, 6, 7, 8};
                else if (sel == 3'd2) m_plan = {5, 6, 7, 8};
                else m_plan = {8};
                if (sel <= 3'd1 && !soap) begin
                    m_mode = 1;
                    m_rem  = 0;
                end else begin
                    enterHeadPhase();
                end
            end
        end else if (m_mode == 1) begin
            if (soap) enterHeadPhase();
        end else if (door) begin
            m_rem--;
            if (m_rem == 0) begin
                void'(m_plan.pop_front());
                enterHeadPhase();
            end
        end
    endtask

    function automatic logic [17:0] expVec();
        logic act;
        act = (m_mode >= 2) && (m_mode <= 8) && door;
        return {4'(m_mode), 8'(m_rem),
                act && ((m_mode == 2 && m_prog != 3'b001) || m_mode == 5),
                act && (m_mode == 2) && (m_prog == 3'b001),
                act && (m_mode == 4 || m_mode == 7 || m_mode == 8),
                act && (m_mode == 3 || m_mode == 6 || m_mode == 8),
                m_mode == 9,
                m_mode == 1};
    endfunction

    function automatic logic [17:0] actualVec();
        return {dut_state, timer_display, valve_in_cold, valve_in_hot,
                valve_out, motor, program_done, soap_warning};
    endfunction

    initial begin
        m_mode = 0;
        m_rem  = 0;
        m_prog = 3'b000;
        forever begin
            @(posedge clk);
            modelStep();
            exp_q.push_back(expVec());
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) checkOutput("cycle", 32'(actualVec()), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic applyStimulus(input logic p, input logic [2:0] s, input logic st,
                                 input logic d, input logic sp);
        power = p;
        sel   = s;
        start = st;
        door  = d;
        soap  = sp;
    endtask

    task automatic startPulse(input logic [2:0] s);
        sel   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int expected, input int budget);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            if (program_done) seen = 1'b1;
        end
        checkOutput(name, seen ? 32'(n) : 32'hffff_ffff, 32'(expected));
    endtask

    task automatic waitState(input string name, input logic [3:0] st, input int tmr, input int budget);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            tick();
            n++;
            if (dut_state == st && (tmr < 0 || int'(timer_display) == tmr)) ok = 1'b1;
        end
        checkOutput(name, 32'(ok), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        #8;
        checkOutput("reset_state", 32'(actualVec()), 32'd0);
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
        tick();

        startPulse(3'b000);
        waitDone("cold_wash_len", 110, 300);

        soap = 1'b0;
        startPulse(3'b001);
        repeat (3) tick();
        checkOutput("soap_warning", 32'(soap_warning), 32'd1);
        soap = 1'b1;
        waitDone("hot_wash_len", 111, 300);

        startPulse(3'b011);
        waitDone("only_dry_len", 20, 100);

        startPulse(3'b111);
        tick();
        checkOutput("start_sel7_ignored", 32'(dut_state), 32'd9);

        startPulse(3'b000);
        waitState("reach_wash20", 4'd3, 20, 100);
        startPulse(3'b010);
        checkOutput("start_in_wash_ignored", 32'(dut_state), 32'd3);
        waitState("reach_wash15", 4'd3, 15, 100);
        door = 1'b0;
        repeat (5) tick();
        checkOutput("door_hold_timer", 32'(timer_display), 32'd15);
        checkOutput("door_motor_off", 32'(motor), 32'd0);
        door = 1'b1;
        n = 0;
        while (dut_state == 4'd3 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("wash_resume_len", 32'(n), 32'd15);

        waitState("reach_rinse", 4'd6, -1, 100);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 32'(actualVec()), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("after_reset_idle", 32'(dut_state), 32'd0);

        startPulse(3'b011);
        repeat (5) tick();
        power = 1'b0;
        tick();
        checkOutput("power_off_idle", 32'(actualVec()), 32'd0);
        startPulse(3'b000);
        checkOutput("start_ignored_power_off", 32'(dut_state), 32'd0);
        power = 1'b1;
        tick();

        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            power = ($urandom_range(0, 79) != 0);
            door  = ($urandom_range(0, 9) != 0);
            soap  = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 11) == 0);
            sel   = 3'($urandom_range(0, 7));
            tick();
        end

        applyStimulus(1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
